// File: rtl/text_cursor_ctrl_pkg.sv
// Shared constants for the text console writer: ASCII codes, FSM state encodings, printable-range helper.
package text_cursor_ctrl_pkg;

  localparam logic [7:0] ASC_BS      = 8'h08;
  localparam logic [7:0] ASC_LF      = 8'h0A;
  localparam logic [7:0] ASC_CR      = 8'h0D;
  localparam logic [7:0] ASC_SP      = 8'h20;
  localparam logic [7:0] ASC_DEL_LIM = 8'h7E;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  function automatic logic is_print(input logic [7:0] c);
    return (c >= ASC_SP) && (c <= ASC_DEL_LIM);
  endfunction

endpackage

// File: rtl/cursor_blink_gen.sv
// Cursor blink phase generator: toggles o_on every BLINK_DIV cycles; i_restart forces the visible phase.
module cursor_blink_gen #(
  parameter int BLINK_DIV = 25000000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_restart,
  output logic o_on
);

  localparam int CW = (BLINK_DIV < 2) ? 1 : $clog2(BLINK_DIV + 1);

  logic [CW-1:0] r_cnt;
  logic          r_on;

  // Counter runs 1..BLINK_DIV so a restart gives a full visible period.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= CW'(1);
      r_on  <= 1'b1;
    end else if (i_restart) begin
      r_cnt <= CW'(1);
      r_on  <= 1'b1;
    end else if (r_cnt == CW'(BLINK_DIV)) begin
      r_cnt <= CW'(1);
      r_on  <= ~r_on;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_on = r_on;

endmodule

// File: rtl/text_cursor_ctrl.sv
// Text console writer: consumes ASCII bytes, writes VRAM at the cursor, blanks each newly entered row.
// Optional blinking cursor when CURSOR_BLINK_EN is defined; otherwise cursor_on is held at 1.
module text_cursor_ctrl
  import text_cursor_ctrl_pkg::*;
#(
  parameter int         COLS       = 80,
  parameter int         ROWS       = 60,
  parameter int         X_W        = 7,
  parameter int         Y_W        = 6,
  parameter logic [7:0] BLANK_CHAR = 8'h20,
  parameter int         BLINK_DIV  = 25000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ps2_read_ready,
  input  logic [7:0]       data_in,
  output logic             ps2_read_done,
  output logic             char_vram_wea,
  output logic [X_W+Y_W-1:0] addr,
  output logic [7:0]       ascii_2_charVram,
  output logic [X_W-1:0]   cursor_x,
  output logic [Y_W-1:0]   cursor_y,
  output logic             cursor_on
);

  localparam logic [X_W-1:0] X_LAST = X_W'(COLS - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(ROWS - 1);

  logic [0:0]         r_state;
  logic [X_W-1:0]     r_x;
  logic [Y_W-1:0]     r_y;
  logic [X_W-1:0]     r_clr_x;
  logic               r_done;
  logic               r_wea;
  logic [X_W+Y_W-1:0] r_addr;
  logic [7:0]         r_data;

  logic               w_accept;
  logic               w_nl;
  logic [Y_W-1:0]     w_y_nl;

  // A byte stays on data_in while done is high, so blocking on r_done avoids double consumption.
  assign w_accept = (r_state == ST_IDLE) && ps2_read_ready && !r_done;
  assign w_nl     = (data_in == ASC_CR) || (data_in == ASC_LF);
  assign w_y_nl   = (r_y == Y_LAST) ? '0 : r_y + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_clr_x <= '0;
      r_done  <= 1'b0;
      r_wea   <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      r_done <= w_accept;
      r_wea  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (is_print(data_in)) begin
              r_wea  <= 1'b1;
              r_addr <= {r_y, r_x};
              r_data <= data_in;
              if (r_x == X_LAST) begin
                r_x     <= '0;
                r_y     <= w_y_nl;
                r_clr_x <= '0;
                r_state <= ST_CLEAR;
              end else begin
                r_x <= r_x + 1'b1;
              end
            end else if (w_nl) begin
              r_x     <= '0;
              r_y     <= w_y_nl;
              r_clr_x <= '0;
              r_state <= ST_CLEAR;
            end else if (data_in == ASC_BS) begin
              if (r_x != '0) begin
                r_x    <= r_x - 1'b1;
                r_wea  <= 1'b1;
                r_addr <= {r_y, r_x - 1'b1};
                r_data <= BLANK_CHAR;
              end else if (r_y != '0) begin
                r_x    <= X_LAST;
                r_y    <= r_y - 1'b1;
                r_wea  <= 1'b1;
                r_addr <= {r_y - 1'b1, X_LAST};
                r_data <= BLANK_CHAR;
              end
            end
          end
        end
        ST_CLEAR: begin
          // r_y already points at the new row; sweep its visible columns only.
          r_wea  <= 1'b1;
          r_addr <= {r_y, r_clr_x};
          r_data <= BLANK_CHAR;
          if (r_clr_x == X_LAST) r_state <= ST_IDLE;
          else                   r_clr_x <= r_clr_x + 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ps2_read_done    = r_done;
  assign char_vram_wea    = r_wea;
  assign addr             = r_addr;
  assign ascii_2_charVram = r_data;
  assign cursor_x         = r_x;
  assign cursor_y         = r_y;

`ifdef CURSOR_BLINK_EN
  logic w_move;

  assign w_move = w_accept &&
                  (is_print(data_in) || w_nl ||
                   ((data_in == ASC_BS) && ((r_x != '0) || (r_y != '0))));

  cursor_blink_gen #(.BLINK_DIV(BLINK_DIV)) u_blink (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_restart (w_move),
    .o_on      (cursor_on)
  );
`else
  assign cursor_on = 1'b1;
`endif

endmodule

// File: tb/tb_text_cursor_ctrl.sv
// Scoreboard bench for text_cursor_ctrl: expected VRAM writes are queued by stimulus, popped by a monitor.
module tb_text_cursor_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ps2_read_ready = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic        ps2_read_done;
  logic        char_vram_wea;
  logic [12:0] addr;
  logic [7:0]  ascii_2_charVram;
  logic [6:0]  cursor_x;
  logic [5:0]  cursor_y;
  logic        cursor_on;

  typedef struct {
    logic [12:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  done_cnt = 0;
  int  exp_done = 0;

  text_cursor_ctrl #(
    .COLS(80), .ROWS(60), .X_W(7), .Y_W(6), .BLANK_CHAR(8'h20), .BLINK_DIV(4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .ps2_read_ready   (ps2_read_ready),
    .data_in          (data_in),
    .ps2_read_done    (ps2_read_done),
    .char_vram_wea    (char_vram_wea),
    .addr             (addr),
    .ascii_2_charVram (ascii_2_charVram),
    .cursor_x         (cursor_x),
    .cursor_y         (cursor_y),
    .cursor_on        (cursor_on)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [12:0] va(input int y, input int x);
    return 13'(y * 128 + x);
  endfunction

  task automatic push_wr(input int y, input int x, input logic [7:0] d);
    wr_t w;
    w.a = va(y, x);
    w.d = d;
    exp_q.push_back(w);
  endtask

  task automatic push_clear(input int y);
    for (int x = 0; x < 80; x++) push_wr(y, x, 8'h20);
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that raised done.
  task automatic send(input logic [7:0] b);
    exp_done++;
    ps2_read_ready = 1'b1;
    data_in        = b;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (ps2_read_done) break;
    end
    if (!ps2_read_done) chk("done_timeout", 32'(ps2_read_done), 32'd1);
    ps2_read_ready = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic chk_cur(input int x, input int y);
    chk("cursor_x", 32'(cursor_x), 32'(x));
    chk("cursor_y", 32'(cursor_y), 32'(y));
  endtask

  task automatic chk_reset_outs();
    chk("rst_done", 32'(ps2_read_done), 32'd0);
    chk("rst_wea",  32'(char_vram_wea), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_data", 32'(ascii_2_charVram), 32'd0);
    chk("rst_cur_on", 32'(cursor_on), 32'd1);
    chk_cur(0, 0);
  endtask

  // Monitor: every write must match the head of the queue, in order.
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (char_vram_wea) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: addr %0h data %0h, expected no write", addr, ascii_2_charVram);
          end else begin
            w = exp_q.pop_front();
            chk("wr_addr", 32'(addr), 32'(w.a));
            chk("wr_data", 32'(ascii_2_charVram), 32'(w.d));
          end
        end
        if (ps2_read_done) done_cnt++;
      end
    end
  end

  initial begin
    int d0;
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_outs();
    rst = 1'b0;

    // Two printable characters at the home position
    push_wr(0, 0, 8'h41); send(8'h41);
    push_wr(0, 1, 8'h42); send(8'h42);
    drain();
    chk_cur(2, 0);
    chk("done_count_ab", 32'(done_cnt), 32'(exp_done));

    // CR to row 1, then backspace wraps back to (79,0)
    push_clear(1); send(8'h0D); drain();
    chk_cur(0, 1);
    push_wr(0, 79, 8'h20); send(8'h08); drain();
    chk_cur(79, 0);

    // Line wrap on the last column
    push_wr(0, 79, 8'h5A); push_clear(1); send(8'h5A); drain();
    chk_cur(0, 1);

    // Walk down to the last row with LF
    for (int y = 2; y < 60; y++) begin
      push_clear(y); send(8'h0A); drain();
    end
    chk_cur(0, 59);

    // Screen wrap: CR on the last row goes to row 0, no write at old spot
    push_clear(0); send(8'h0D); drain();
    chk_cur(0, 0);

    // Backspace at home: consumed, nothing else
    d0 = done_cnt;
    send(8'h08); drain();
    chk_cur(0, 0);
    chk("bs_home_done", 32'(done_cnt - d0), 32'd1);

    for (int y = 1; y <= 3; y++) begin
      push_clear(y); send(8'h0D); drain();
    end
    chk_cur(0, 3);
    push_wr(2, 79, 8'h20); send(8'h08); drain();
    chk_cur(79, 2);

    // Unhandled control code: consumed, no write, no move
    send(8'h1B); drain();
    chk_cur(79, 2);

    push_clear(3); send(8'h0D); drain();
    chk_cur(0, 3);

    // Ready held for 6 cycles: accept, skip, accept, skip, accept, skip
    d0 = done_cnt;
    push_wr(3, 0, 8'h51); push_wr(3, 1, 8'h51); push_wr(3, 2, 8'h51);
    exp_done += 3;
    ps2_read_ready = 1'b1;
    data_in        = 8'h51;
    repeat (6) @(posedge clk);
    #1 ps2_read_ready = 1'b0;
    drain();
    chk("held_ready_accepts", 32'(done_cnt - d0), 32'd3);
    chk_cur(3, 3);

    // Cursor phase right after a typed character
    push_wr(3, 3, 8'h61); send(8'h61);
`ifdef CURSOR_BLINK_EN
    for (int i = 0; i < 8; i++) begin
      chk("blink_phase", 32'(cursor_on), (i < 4) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
    end
`else
    for (int i = 0; i < 4; i++) begin
      chk("cursor_on_const", 32'(cursor_on), 32'd1);
      @(posedge clk); #1;
    end
`endif
    drain();
    chk_cur(4, 3);

    // Reset in the middle of a row clear
    push_clear(4); send(8'h0D);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    exp_q.delete();
    #1 chk_reset_outs();
    @(posedge clk); #1 rst = 1'b0;
    chk_reset_outs();

    push_wr(0, 0, 8'h6B); send(8'h6B); drain();
    chk_cur(1, 0);
    chk("done_count_final", 32'(done_cnt), 32'(exp_done));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
